elbeth_dpram_param: RTL and testbench

Parametrised true dual-port synchronous memory with byte-lane write strobes. It is the next generation of elbeth_memory and is generalised in data width, depth and read latency. Each port has a pipelined request/ready handshake, a defined same-word collision policy and a collision flag. It sits between the core's instruction port (A) and load/store port (B) and on-chip RAM.

---
 rtl/elbeth_mem_pkg.sv | 15 +
 rtl/elbeth_mem_resp_pipe.sv | 31 +++
 rtl/elbeth_dpram_param.sv | 84 ++++++++
 tb/tb_elbeth_dpram_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_mem_pkg.sv
// elbeth_mem_pkg: shared sizing helpers and collision-policy constants for the elbeth memories
package elbeth_mem_pkg;
    localparam int LATENCY_MAX = 4;
    localparam bit RF_OLD = 1'b1;
    localparam bit PRIO_A = 1'b1;
    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction
    function automatic int lane_bits(input int bytes);
        return $clog2(bytes);
    endfunction
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/elbeth_mem_resp_pipe.sv
// elbeth_mem_resp_pipe: LATENCY-deep valid/data delay line for one memory port
module elbeth_mem_resp_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic [DATA_W-1:0] data_out
);
    logic [LATENCY-1:0] v;
    logic [DATA_W-1:0]  d [LATENCY];
    // shift valid bits; data stages load only alongside a valid so the last stage holds between responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < LATENCY; i++) d[i] <= '0;
        end else begin
            v[0] <= valid;
            if (valid) d[0] <= data;
            for (int i = 1; i < LATENCY; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) d[i] <= d[i-1];
            end
        end
    end
    assign ready    = v[LATENCY-1];
    assign data_out = d[LATENCY-1];
endmodule

// File: rtl/elbeth_dpram_param.sv
// elbeth_dpram_param: true dual-port byte-strobed RAM with pipelined responses and collision merge
module elbeth_dpram_param import elbeth_mem_pkg::*; #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 8,
    parameter int LATENCY    = 1,
    parameter bit READ_FIRST = 1'b0,
    parameter bit A_WINS     = 1'b1,
    parameter int BYTES      = lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              amem_enable,
    input  logic [ADDR_W-1:0] amem_addr,
    input  logic [DATA_W-1:0] amem_data_in,
    input  logic [BYTES-1:0]  amem_wr,
    output logic [DATA_W-1:0] amem_data_out,
    output logic              amem_ready,
    input  logic              bmem_enable,
    input  logic [ADDR_W-1:0] bmem_addr,
    input  logic [DATA_W-1:0] bmem_data_in,
    input  logic [BYTES-1:0]  bmem_wr,
    output logic [DATA_W-1:0] bmem_data_out,
    output logic              bmem_ready,
    output logic              mem_collision
);
    localparam int LB  = lane_bits(BYTES);
    localparam int IW  = idx_w(DEPTH);
    localparam int LAT = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : (LATENCY < 1) ? 1 : LATENCY;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IW-1:0]     a_idx, b_idx;
    logic [BYTES-1:0]  a_we, b_we;
    logic              same_word, coll;
    logic [DATA_W-1:0] a_old, b_old, a_new, b_new, a_rd, b_rd;
    logic              unused_addr;

    assign a_idx       = amem_addr[LB +: IW];
    assign b_idx       = bmem_addr[LB +: IW];
    assign unused_addr = ^{amem_addr, bmem_addr};
    assign a_we        = amem_enable ? amem_wr : '0;
    assign b_we        = bmem_enable ? bmem_wr : '0;
    assign same_word   = amem_enable & bmem_enable & (a_idx == b_idx);
    assign a_old       = mem[a_idx];
    assign b_old       = mem[b_idx];

    // post-write view of each port's word; on a shared word both views merge both ports' lanes identically
    always_comb begin
        a_new = a_old;
        b_new = b_old;
        for (int i = 0; i < BYTES; i++) begin
            a_new[8*i +: 8] = (a_we[i] && (A_WINS == PRIO_A || !(same_word && b_we[i]))) ? amem_data_in[8*i +: 8] :
                              (same_word && b_we[i]) ? bmem_data_in[8*i +: 8] : a_old[8*i +: 8];
            b_new[8*i +: 8] = (b_we[i] && (A_WINS != PRIO_A || !(same_word && a_we[i]))) ? bmem_data_in[8*i +: 8] :
                              (same_word && a_we[i]) ? amem_data_in[8*i +: 8] : b_old[8*i +: 8];
        end
    end

    assign a_rd = ((|a_we) || READ_FIRST != RF_OLD) ? a_new : a_old;
    assign b_rd = ((|b_we) || READ_FIRST != RF_OLD) ? b_new : b_old;

    // array update; contents survive reset, so no reset branch here
    always_ff @(posedge clk) begin
        if (!rst && (|a_we)) mem[a_idx] <= a_new;
        if (!rst && (|b_we)) mem[b_idx] <= b_new;
    end

    // collision flag pulses for the cycle after a same-word access involving a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) coll <= 1'b0;
        else     coll <= same_word & ((|a_we) | (|b_we));
    end
    assign mem_collision = coll;

    elbeth_mem_resp_pipe #(.DATA_W(DATA_W), .LATENCY(LAT)) u_pipe_a (
        .clk(clk), .rst(rst), .valid(amem_enable), .data(a_rd),
        .ready(amem_ready), .data_out(amem_data_out)
    );

    elbeth_mem_resp_pipe #(.DATA_W(DATA_W), .LATENCY(LAT)) u_pipe_b (
        .clk(clk), .rst(rst), .valid(bmem_enable), .data(b_rd),
        .ready(bmem_ready), .data_out(bmem_data_out)
    );
endmodule

// File: tb/tb_elbeth_dpram_param.sv
// tb_elbeth_dpram_param: two configurations driven in lockstep against a byte-level reference model
module tb_elbeth_dpram_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_en = 1'b0, b_en = 1'b0;
    logic [7:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_din = '0, b_din = '0;
    logic [3:0]  a_wr = '0, b_wr = '0;
    logic [31:0] a_do [2];
    logic [31:0] b_do [2];
    logic        a_rdy [2];
    logic        b_rdy [2];
    logic        coll [2];

    elbeth_dpram_param #(.DATA_W(32), .DEPTH(64), .ADDR_W(8), .LATENCY(1), .READ_FIRST(1'b0), .A_WINS(1'b1)) dut0 (
        .clk(clk), .rst(rst),
        .amem_enable(a_en), .amem_addr(a_addr), .amem_data_in(a_din), .amem_wr(a_wr),
        .amem_data_out(a_do[0]), .amem_ready(a_rdy[0]),
        .bmem_enable(b_en), .bmem_addr(b_addr), .bmem_data_in(b_din), .bmem_wr(b_wr),
        .bmem_data_out(b_do[0]), .bmem_ready(b_rdy[0]),
        .mem_collision(coll[0])
    );

    elbeth_dpram_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(8), .LATENCY(3), .READ_FIRST(1'b1), .A_WINS(1'b0)) dut1 (
        .clk(clk), .rst(rst),
        .amem_enable(a_en), .amem_addr(a_addr), .amem_data_in(a_din), .amem_wr(a_wr),
        .amem_data_out(a_do[1]), .amem_ready(a_rdy[1]),
        .bmem_enable(b_en), .bmem_addr(b_addr), .bmem_data_in(b_din), .bmem_wr(b_wr),
        .bmem_data_out(b_do[1]), .bmem_ready(b_rdy[1]),
        .mem_collision(coll[1])
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    resp_t       q [4][$];
    logic [31:0] last [4];
    bit          flag [2];
    logic [7:0]  mb [2][256];
    int          lat [2] = '{1, 3};
    int          dep [2] = '{64, 16};
    bit          rf [2] = '{1'b0, 1'b1};
    bit          awin [2] = '{1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int k, input int idx);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mb[k][idx*4 + i];
        return w;
    endfunction

    task automatic put(input int k, input int idx, input logic [3:0] wr, input logic [31:0] d);
        for (int i = 0; i < 4; i++) if (wr[i]) mb[k][idx*4 + i] = d[8*i +: 8];
    endtask

    task automatic model_step(input int k);
        int ia, ib;
        logic [31:0] pre_a, pre_b;
        ia = (int'(a_addr) >> 2) % dep[k];
        ib = (int'(b_addr) >> 2) % dep[k];
        pre_a = word_of(k, ia);
        pre_b = word_of(k, ib);
        if (awin[k]) begin
            if (b_en) put(k, ib, b_wr, b_din);
            if (a_en) put(k, ia, a_wr, a_din);
        end else begin
            if (a_en) put(k, ia, a_wr, a_din);
            if (b_en) put(k, ib, b_wr, b_din);
        end
        if (a_en) q[2*k].push_back('{cyc + lat[k] - 1, (a_wr == 4'h0 && rf[k]) ? pre_a : word_of(k, ia)});
        if (b_en) q[2*k+1].push_back('{cyc + lat[k] - 1, (b_wr == 4'h0 && rf[k]) ? pre_b : word_of(k, ib)});
        flag[k] = a_en && b_en && ia == ib && (a_wr != 4'h0 || b_wr != 4'h0);
    endtask

    task automatic check_port(input int i, input logic rdy, input logic [31:0] dout);
        bit exp_r;
        exp_r = q[i].size() > 0 && q[i][0].due == cyc;
        if (exp_r) begin
            last[i] = q[i][0].data;
            q[i].delete(0);
        end
        chk($sformatf("d%0d_p%0d_ready_c%0d", i / 2, i % 2, cyc), 32'(rdy), 32'(exp_r));
        chk($sformatf("d%0d_p%0d_data_c%0d", i / 2, i % 2, cyc), dout, last[i]);
    endtask

    task automatic step(input logic ae, input logic [7:0] aa, input logic [31:0] ad, input logic [3:0] aw,
                        input logic be, input logic [7:0] ba, input logic [31:0] bd, input logic [3:0] bw);
        a_en = ae; a_addr = aa; a_din = ad; a_wr = aw;
        b_en = be; b_addr = ba; b_din = bd; b_wr = bw;
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_port(2*k, a_rdy[k], a_do[k]);
            check_port(2*k+1, b_rdy[k], b_do[k]);
            chk($sformatf("d%0d_collision_c%0d", k, cyc), 32'(coll[k]), 32'(flag[k]));
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 8'h0, 32'h0, 4'h0);
    endtask

    task automatic rd_a(input logic [7:0] aa);
        step(1'b1, aa, 32'h0, 4'h0, 1'b0, 8'h0, 32'h0, 4'h0);
    endtask

    task automatic wr_a(input logic [7:0] aa, input logic [31:0] ad, input logic [3:0] aw);
        step(1'b1, aa, ad, aw, 1'b0, 8'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_en = 1'b0;
        b_en = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_rst_a_ready", k), 32'(a_rdy[k]), 32'h0);
            chk($sformatf("d%0d_rst_b_ready", k), 32'(b_rdy[k]), 32'h0);
            chk($sformatf("d%0d_rst_collision", k), 32'(coll[k]), 32'h0);
            chk($sformatf("d%0d_rst_a_data", k), a_do[k], 32'h0);
            chk($sformatf("d%0d_rst_b_data", k), b_do[k], 32'h0);
            flag[k] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            last[i] = '0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 32; i++)
            step(1'b1, 8'(i*8), 32'h0, 4'hF, 1'b1, 8'(i*8 + 4), 32'h0, 4'hF);
        // write from B, read back on A
        step(1'b0, 8'h0, 32'h0, 4'h0, 1'b1, 8'h08, 32'h000000AB, 4'b0001);
        rd_a(8'h08);
        idle(3);
        chk("t1_d0", a_do[0], 32'h000000AB);
        chk("t1_d1", a_do[1], 32'h000000AB);
        // byte lanes and misaligned read
        wr_a(8'h10, 32'hFFFFFFFF, 4'hF);
        wr_a(8'h10, 32'h00001200, 4'b0010);
        rd_a(8'h10);
        rd_a(8'h13);
        idle(3);
        chk("t2_d0", a_do[0], 32'hFFFF12FF);
        chk("t2_d1", a_do[1], 32'hFFFF12FF);
        // write-write collision
        step(1'b1, 8'h20, 32'h11111111, 4'b0011, 1'b1, 8'h20, 32'h22222222, 4'b0110);
        rd_a(8'h20);
        idle(3);
        chk("t3_d0_awins", a_do[0], 32'h00221111);
        chk("t3_d1_bwins", a_do[1], 32'h00222211);
        // read-write collision
        wr_a(8'h20, 32'hAAAAAAAA, 4'hF);
        step(1'b1, 8'h20, 32'h0, 4'h0, 1'b1, 8'h20, 32'h55555555, 4'hF);
        idle(3);
        chk("t4_d0_newdata", a_do[0], 32'h55555555);
        chk("t4_d1_olddata", a_do[1], 32'hAAAAAAAA);
        // back-to-back reads
        rd_a(8'h00);
        rd_a(8'h04);
        rd_a(8'h08);
        idle(3);
        chk("t5_d1_last", a_do[1], 32'h000000AB);
        // reset with reads in flight
        rd_a(8'h04);
        rd_a(8'h10);
        do_reset();
        idle(4);
        rd_a(8'h10);
        idle(3);
        chk("t6_d0_persist", a_do[0], 32'hFFFF12FF);
        chk("t6_d1_persist", a_do[1], 32'hFFFF12FF);
        // randomized traffic biased towards a few words to provoke collisions
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255)),
                 $urandom,
                 $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255)),
                 $urandom,
                 $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)));
        end
        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
